y86_regfile_wb: RTL
===================

Name: y86_regfile_wb

Overview:
- Parametrised successor to the SEQ decode/writeback register file, shared by the SEQ and PIPE cores.
- Two combinational read ports (decode stage: srcA, srcB) and two write ports (writeback stage: E and M channels), all on one clock.
- Optional same-cycle write-to-read bypass and a write stall.
- Sticky illegal-address flag.

Parameters:
- DATA_W, 64, register and data width in bits.
- NREG, 15, number of architectural registers (indices 0..NREG-1).
- ADDR_W, 4, register-index width; 2**ADDR_W must be greater than NREG.
- RNONE, 4'hF, "no register" index; must be ≥ NREG.
- BYPASS, 1, 1 = read ports return the value being written this cycle; 0 = read ports return stored contents only.

Ports:
- clk  in  1  system clock, rising edge active
- rst_n  in  1  asynchronous active-low reset
- srcA  in  ADDR_W  read index A
- srcB  in  ADDR_W  read index B
- valA  out  DATA_W  read data A
- valB  out  DATA_W  read data B
- wb_en  in  1  writeback enable; 0 = stall, no writes
- dstE  in  ADDR_W  E-channel destination (already gated by cnd for cmov upstream)
- valE  in  DATA_W  E-channel data
- dstM  in  ADDR_W  M-channel destination
- valM  in  DATA_W  M-channel data
- addr_err  out  1  sticky flag for an illegal index

Behaviour:
- Reset (asynchronous on rst_n falling edge): all NREG registers = 0 and addr_err = 0.
- Reset effect on reads: while rst_n = 0, valA = valB = 0; the read path has no reset term.
- Reset mid-write: a write coincident with rst_n = 0 is discarded.
- Write timing: on posedge clk with rst_n = 1 and wb_en = 1:
  - reg[dstE] ← valE if dstE < NREG;
  - reg[dstM] ← valM if dstM < NREG.
- Write conflict: if dstE == dstM and the index is legal, valM wins (popq %rsp semantics). Exactly one write lands.
- Write suppression: RNONE or any other index ≥ NREG suppresses that channel's write. When wb_en = 0 no register changes.
- Read latency: 0 cycles (combinational). The value written at edge N is visible on reads after edge N.
- Read selection, in priority order for each port X ∈ {A, B}:
  1. srcX ≥ NREG (including RNONE) → valX = 0.
  2. BYPASS=1 and wb_en=1 and srcX == dstM → valX = valM.
  3. BYPASS=1 and wb_en=1 and srcX == dstE → valX = valE.
  4. Otherwise valX = reg[srcX].
- Independent ports: srcA == srcB is legal; both ports return identical data.
- addr_err:
  - Set on posedge clk if any of srcA, srcB, dstE, dstM is in the range NREG..2**ADDR_W-1 excluding RNONE.
  - For dstE and dstM this is checked only when wb_en = 1.
  - Cleared only by reset.
- Data widths: data is stored and returned at full DATA_W with no truncation or sign handling. Index comparisons are unsigned ADDR_W.
- No X propagation: an unwritten register reads 0 after reset.

Decomposition:
- Shared package y86_pkg holds:
  - register-index constants: RRSP = 4'h4, RNONE = 4'hF, and the register names 0..14;
  - DATA_W and ADDR_W defaults;
  - icode constants, reused by the decode-stage control that drives srcA/srcB/dstE/dstM.
- One sub-module, y86_regfile_rdport, instantiated twice: the index-legality check, the bypass mux and the storage select for a single read port. The write logic and addr_err stay in the top module.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after writes; read srcA=1, srcB=2 → valA=0, valB=0 immediately (asynchronous), addr_err=0.
- Basic write/read: wb_en=1, dstE=1, valE=100, dstM=RNONE; after the edge set srcA=1 → valA=100. Then dstE=2, valE=200; srcB=2 → valB=200 after the edge, and reg1 still reads 100.
- Same-destination conflict: dstE=4, valE=0x1000, dstM=4, valM=0x2000 → after the edge srcA=4 gives 0x2000.
- Bypass: BYPASS=1, pre-edge dstE=3, valE=77, srcA=3 → valA=77 in the same cycle. With BYPASS=0, valA equals the old reg3 until the edge, then 77. With wb_en=0 in either build → no bypass and reg3 is unchanged after the edge.
- RNONE and stall: srcA=RNONE → valA=0, addr_err stays 0. wb_en=0, dstE=5, valE=9 → reg5 is unchanged after the edge.
- Illegal index: NREG=15, ADDR_W=5, RNONE=5'h1F; dstE=20 with wb_en=1 → no register changes, addr_err=1 after the edge and held until rst_n=0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: register indices, instruction codes and width defaults
// used by the register file and the decode-stage control that drives its indices.
package y86_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_NREG   = 15;

    localparam logic [3:0] RRAX  = 4'h0;
    localparam logic [3:0] RRCX  = 4'h1;
    localparam logic [3:0] RRDX  = 4'h2;
    localparam logic [3:0] RRBX  = 4'h3;
    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RRBP  = 4'h5;
    localparam logic [3:0] RRSI  = 4'h6;
    localparam logic [3:0] RRDI  = 4'h7;
    localparam logic [3:0] RR8   = 4'h8;
    localparam logic [3:0] RR9   = 4'h9;
    localparam logic [3:0] RR10  = 4'hA;
    localparam logic [3:0] RR11  = 4'hB;
    localparam logic [3:0] RR12  = 4'hC;
    localparam logic [3:0] RR13  = 4'hD;
    localparam logic [3:0] RR14  = 4'hE;
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [3:0] {
        IHALT   = 4'h0,
        INOP    = 4'h1,
        IRRMOVQ = 4'h2,
        IIRMOVQ = 4'h3,
        IRMMOVQ = 4'h4,
        IMRMOVQ = 4'h5,
        IOPQ    = 4'h6,
        IJXX    = 4'h7,
        ICALL   = 4'h8,
        IRET    = 4'h9,
        IPUSHQ  = 4'hA,
        IPOPQ   = 4'hB
    } icode_e;

endpackage

// File: rtl/y86_regfile_rdport.sv
// One combinational read port: index legality, write-to-read bypass, storage select.
module y86_regfile_rdport #(
    parameter int DATA_W = 64,
    parameter int NREG   = 15,
    parameter int ADDR_W = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0] src_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] dstE_i,
    input  logic [DATA_W-1:0] valE_i,
    input  logic [ADDR_W-1:0] dstM_i,
    input  logic [DATA_W-1:0] valM_i,
    input  logic [DATA_W-1:0] regs_i [NREG],
    output logic [DATA_W-1:0] val_o
);
    import y86_pkg::*;

    localparam logic [ADDR_W-1:0] NREG_IDX = ADDR_W'(NREG);

    logic byp_en;
    assign byp_en = BYPASS & wr_en_i;

    // M is checked before E so a same-index conflict forwards the value that lands.
    always_comb begin
        val_o = '0;
        if (src_i >= NREG_IDX) begin
            val_o = '0;
        end else if (byp_en && (src_i == dstM_i)) begin
            val_o = valM_i;
        end else if (byp_en && (src_i == dstE_i)) begin
            val_o = valE_i;
        end else begin
            val_o = regs_i[src_i];
        end
    end

endmodule

// File: rtl/y86_regfile_wb.sv
// Y86 register file: two combinational read ports, E/M writeback ports with
// optional bypass, write stall and a sticky illegal-index flag.
module y86_regfile_wb #(
    parameter int DATA_W = y86_pkg::DEF_DATA_W,
    parameter int NREG   = y86_pkg::DEF_NREG,
    parameter int ADDR_W = y86_pkg::DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RNONE = ADDR_W'(y86_pkg::RNONE),
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [DATA_W-1:0] valM,
    output logic              addr_err
);
    import y86_pkg::*;

    localparam logic [ADDR_W-1:0] NREG_IDX = ADDR_W'(NREG);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              addr_err_q;
    logic              addr_err_d;

    function automatic logic is_illegal(input logic [ADDR_W-1:0] idx);
        return (idx >= NREG_IDX) && (idx != RNONE);
    endfunction

    // E is applied first and M second, so M wins when both target one register.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (wb_en && (dstE == ADDR_W'(i))) begin
                regs_d[i] = valE;
            end
            if (wb_en && (dstM == ADDR_W'(i))) begin
                regs_d[i] = valM;
            end
        end
    end

    always_comb begin
        addr_err_d = addr_err_q | is_illegal(srcA) | is_illegal(srcB)
                   | (wb_en & (is_illegal(dstE) | is_illegal(dstM)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            addr_err_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign addr_err = addr_err_q;

    // Nothing is written while reset is held, so there is nothing to forward either.
    logic              wr_live;
    logic [ADDR_W-1:0] rd_src [2];
    logic [DATA_W-1:0] rd_val [2];

    assign wr_live   = wb_en & rst_n;
    assign rd_src[0] = srcA;
    assign rd_src[1] = srcB;
    assign valA      = rd_val[0];
    assign valB      = rd_val[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            y86_regfile_rdport #(
                .DATA_W (DATA_W),
                .NREG   (NREG),
                .ADDR_W (ADDR_W),
                .BYPASS (BYPASS)
            ) u_rdport (
                .src_i   (rd_src[gi]),
                .wr_en_i (wr_live),
                .dstE_i  (dstE),
                .valE_i  (valE),
                .dstM_i  (dstM),
                .valM_i  (valM),
                .regs_i  (regs_q),
                .val_o   (rd_val[gi])
            );
        end
    endgenerate

endmodule
